serial_spi_flash_reader: RTL and testbench
==========================================

SERIAL_SPI_FLASH_READER -- requirements
Module: serial_spi_flash_reader

Interface
REQ-001 SHALL have parameter WAKE_CYCLES, default 30, meaning clk cycles cs is held high after the wakeup command before the next command.
REQ-002 SHALL have parameter CS_GAP, default 2, meaning the minimum number of clk cycles cs is held high between commands.
REQ-003 SHALL have parameter EXPECTED_ID, default 24'h010000, meaning the JEDEC ID that must be returned by the read-ID command.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have ports req_valid input 1, req_addr input 24, req_len input 9 (1..256 bytes; 0 treated as 256), and req_ready output 1.
REQ-007 SHALL have ports data_out output 8, data_valid output 1, and data_ready input 1, forming the read byte stream.
REQ-008 SHALL have ports init_done output 1 (init sequence passed) and init_error output 1 (ID mismatch, sticky until rst).
REQ-009 SHALL have ports cs output 1 (active-low), sclk output 1, si output 1 (controller to flash), and so input 1 (flash to controller).

Function
REQ-010 SHALL run SPI mode 0, MSB first, with sclk idle low and each bit lasting 2 clk cycles: phase L (sclk=0, si driven) then phase H (sclk=1, si held).
REQ-011 SHALL sample so on the clk edge that ends phase L (the edge raising sclk), and SHALL change si only on the edge that ends phase H.
REQ-012 SHALL assert cs low for at least one clk cycle before the first phase L of a command, and SHALL deassert it one cycle after the final phase H.
REQ-013 SHALL step the FSM through WAKE_CMD, WAKE_WAIT, ID_CMD, ID_RECV, then READY on match or ERROR on mismatch; reads SHALL run READY, RD_CMD, RD_ADDR, RD_DUMMY, RD_DATA, GAP, READY.
REQ-014 SHALL, in WAKE_CMD after reset release, send 8'hAB, then in WAKE_WAIT hold cs high for WAKE_CYCLES cycles.
REQ-015 SHALL, in ID_CMD, send 8'h9F, then in ID_RECV clock 24 further bits into a shift register while si is held 0.
REQ-016 SHALL enter READY and set init_done=1 when the captured ID equals EXPECTED_ID, or else enter ERROR and set init_error=1.
REQ-017 SHALL keep ERROR terminal until rst, with req_ready=0 and cs=1.
REQ-018 SHALL assert req_ready only in READY once at least CS_GAP cycles of cs high have elapsed; a transfer SHALL be accepted on req_valid&&req_ready, latching addr and len.
REQ-019 SHALL, for a read, send 8'h0B, then addr[23:16], addr[15:8], addr[7:0], then one dummy byte 8'h00, then receive len bytes.
REQ-020 SHALL load each received byte into data_out and set data_valid=1 on the edge that samples its bit 0; data_valid SHALL clear on data_valid&&data_ready.
REQ-021 SHALL stall before the phase L of bit 7 of the next byte, holding sclk=0 and cs=0, while data_valid=1 and data_ready=0; it SHALL resume on the cycle after the handshake.
REQ-022 SHALL NOT stall when data_ready=1 at the byte boundary (zero bubble).
REQ-023 SHALL, after the last byte is sampled, raise cs without waiting for its handshake; READY SHALL NOT reassert req_ready until that byte is consumed.
REQ-024 SHALL use a 9-bit byte counter for len so that 256 is the maximum; the address SHALL NOT wrap internally, because the flash auto-increments.
REQ-025 SHALL ignore req_valid outside READY; a request held across init SHALL be accepted when READY is reached.

Reset
REQ-026 SHALL, on rst asserted at any time including mid-transfer, immediately force cs=1, sclk=0, si=0, req_ready=0, data_valid=0, data_out=0, init_done=0, init_error=0, and the FSM to WAKE_CMD.
REQ-027 SHALL, on rst release, restart the full init sequence, with the first cs fall no earlier than the second clk edge after release.

Verification
REQ-028 SHALL cover init: reset release with the mock returning ID 010000 -> 0xAB then 0x9F seen on si, init_done=1, init_error=0.
REQ-029 SHALL cover ID mismatch: mock ID 0xEF4018 -> init_error=1, req_ready stays 0 for 1000 cycles.
REQ-030 SHALL cover a read: addr 0x000004, len 3, data_ready=1 -> si bytes 0B 00 00 04 00; data_out equals buffer bytes 4, 5, 6 in order; cs rises once.
REQ-031 SHALL cover backpressure: len 4 with data_ready low for 20 cycles after byte 1 -> sclk frozen low, cs low, no byte lost or duplicated.
REQ-032 SHALL cover len 0: 256 bytes delivered, then req_ready returns.
REQ-033 SHALL cover reset mid-transfer: rst pulsed during byte 2 of the data phase -> cs=1 asynchronously, data_valid=0, then 0xAB re-sent.

Source files
------------

// File: rtl/serial_spi_flash_reader.sv
// SPI flash read controller (mode 0, MSB first, two clk cycles per bit).
// After reset it wakes the flash (0xAB), waits WAKE_CYCLES with cs high, then
// reads the JEDEC ID (0x9F) and compares it against EXPECTED_ID. On a match
// it serves fast-read requests (0x0B + 24-bit address + dummy byte) and
// streams the returned bytes over a valid/ready interface.
//
// Ports:
//   clk, rst                          system clock, async active-high reset
//   req_valid/req_addr/req_len/req_ready
//                                     read request (len 0 means 256 bytes)
//   data_out/data_valid/data_ready    received byte stream
//   init_done, init_error             init passed / ID mismatch (sticky)
//   cs, sclk, si, so                  SPI bus (cs active-low)
module serial_spi_flash_reader #(
  parameter int unsigned WAKE_CYCLES = 30,
  parameter int unsigned CS_GAP      = 2,
  parameter logic [23:0] EXPECTED_ID = 24'h010000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [23:0] req_addr,
  input  logic [8:0]  req_len,
  output logic        req_ready,
  output logic [7:0]  data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        init_done,
  output logic        init_error,
  output logic        cs,
  output logic        sclk,
  output logic        si,
  input  logic        so
);

  localparam int unsigned CntMax = (WAKE_CYCLES > CS_GAP) ? WAKE_CYCLES : CS_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1) + 1;
  localparam logic [CntW-1:0] CntSat  = CntW'(CntMax);
  localparam logic [CntW-1:0] WakeCnt = CntW'(WAKE_CYCLES);
  localparam logic [CntW-1:0] GapCnt  = CntW'(CS_GAP);

  typedef enum logic [3:0] {
    StWakeCmd, StWakeWait, StIdCmd, StIdRecv, StReady,
    StRdCmd, StRdAddr, StRdDummy, StRdData, StGap, StError
  } state_e;

  // Bit engine: Setup is the cs-low cycle before the first phase L,
  // Hold is the cs-low cycle after the final phase H.
  typedef enum logic [2:0] {EngIdle, EngSetup, EngLow, EngHigh, EngHold} eng_e;

  state_e          state_q;
  eng_e            eng_q;
  logic [2:0]      bit_cnt;
  logic [8:0]      byte_cnt;
  logic [7:0]      tx_sr;
  logic [6:0]      rx_sr;
  logic [23:0]     id_q;
  logic [23:0]     addr_q;
  logic [8:0]      len_q;
  logic [CntW-1:0] cs_high_cnt;

  logic [7:0] rx_byte;
  logic [7:0] start_cmd;
  logic       is_cmd_state;
  logic       stall;
  logic [8:0] len_eff;

  assign rx_byte      = {rx_sr, so};
  assign is_cmd_state = (state_q == StWakeCmd) || (state_q == StIdCmd) || (state_q == StRdCmd);
  // Hold off bit 7 of the next data byte until the previous byte is taken.
  assign stall        = (state_q == StRdData) && (bit_cnt == 3'd7) && data_valid && !data_ready;
  assign len_eff      = (req_len == 9'd0) ? 9'd256 : req_len;

  always_comb begin
    start_cmd = 8'h00;
    case (state_q)
      StWakeCmd: start_cmd = 8'hAB;
      StIdCmd:   start_cmd = 8'h9F;
      StRdCmd:   start_cmd = 8'h0B;
      default:   start_cmd = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StWakeCmd;
      eng_q       <= EngIdle;
      bit_cnt     <= 3'd7;
      byte_cnt    <= 9'd0;
      tx_sr       <= 8'h00;
      rx_sr       <= 7'h00;
      id_q        <= 24'h0;
      addr_q      <= 24'h0;
      len_q       <= 9'd0;
      cs_high_cnt <= '0;
      cs          <= 1'b1;
      sclk        <= 1'b0;
      si          <= 1'b0;
      req_ready   <= 1'b0;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      init_done   <= 1'b0;
      init_error  <= 1'b0;
    end else begin
      if (cs) begin
        if (cs_high_cnt != CntSat) cs_high_cnt <= cs_high_cnt + CntW'(1);
      end else begin
        cs_high_cnt <= '0;
      end

      if (data_valid && data_ready) data_valid <= 1'b0;

      unique case (eng_q)
        EngIdle: begin
          // Nonzero count also delays the first cs fall after reset by one edge.
          if (is_cmd_state && cs_high_cnt != '0) begin
            cs      <= 1'b0;
            tx_sr   <= start_cmd;
            si      <= start_cmd[7];
            bit_cnt <= 3'd7;
            eng_q   <= EngSetup;
          end
        end
        EngSetup: eng_q <= EngLow;
        EngLow: begin
          if (!stall) begin
            sclk  <= 1'b1;
            rx_sr <= rx_byte[6:0];
            eng_q <= EngHigh;
            if (bit_cnt == 3'd0) begin
              if (state_q == StIdRecv) id_q <= {id_q[15:0], rx_byte};
              if (state_q == StRdData) begin
                data_out   <= rx_byte;
                data_valid <= 1'b1;
              end
            end
          end
        end
        EngHigh: begin
          sclk <= 1'b0;
          if (bit_cnt != 3'd0) begin
            bit_cnt <= bit_cnt - 3'd1;
            si      <= tx_sr[bit_cnt - 3'd1];
            eng_q   <= EngLow;
          end else begin
            // Byte boundary: pick the next byte or close the command.
            bit_cnt <= 3'd7;
            si      <= 1'b0;
            eng_q   <= EngLow;
            case (state_q)
              StWakeCmd: eng_q <= EngHold;
              StIdCmd: begin
                state_q  <= StIdRecv;
                tx_sr    <= 8'h00;
                byte_cnt <= 9'd2;
              end
              StIdRecv: begin
                if (byte_cnt == 9'd0) eng_q <= EngHold;
                else byte_cnt <= byte_cnt - 9'd1;
              end
              StRdCmd: begin
                state_q  <= StRdAddr;
                tx_sr    <= addr_q[23:16];
                si       <= addr_q[23];
                addr_q   <= {addr_q[15:0], 8'h00};
                byte_cnt <= 9'd2;
              end
              StRdAddr: begin
                if (byte_cnt == 9'd0) begin
                  state_q <= StRdDummy;
                  tx_sr   <= 8'h00;
                end else begin
                  tx_sr    <= addr_q[23:16];
                  si       <= addr_q[23];
                  addr_q   <= {addr_q[15:0], 8'h00};
                  byte_cnt <= byte_cnt - 9'd1;
                end
              end
              StRdDummy: begin
                state_q  <= StRdData;
                byte_cnt <= len_q;
              end
              StRdData: begin
                if (byte_cnt == 9'd1) eng_q <= EngHold;
                else byte_cnt <= byte_cnt - 9'd1;
              end
              default: eng_q <= EngHold;
            endcase
          end
        end
        EngHold: begin
          cs    <= 1'b1;
          eng_q <= EngIdle;
          case (state_q)
            StWakeCmd: state_q <= StWakeWait;
            StIdRecv: begin
              if (id_q == EXPECTED_ID) begin
                state_q   <= StReady;
                init_done <= 1'b1;
              end else begin
                state_q    <= StError;
                init_error <= 1'b1;
              end
            end
            default: state_q <= StGap;
          endcase
        end
        default: eng_q <= EngIdle;
      endcase

      // States that only wait with cs high.
      case (state_q)
        StWakeWait: if (cs_high_cnt >= WakeCnt) state_q <= StIdCmd;
        StGap:      if (cs_high_cnt >= GapCnt) state_q <= StReady;
        StReady: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            addr_q    <= req_addr;
            len_q     <= len_eff;
            state_q   <= StRdCmd;
          end else begin
            // Wait for the last byte of the previous read to be consumed.
            req_ready <= (cs_high_cnt >= GapCnt) && !(data_valid && !data_ready);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_spi_flash_reader.sv
// Directed bench for serial_spi_flash_reader with a behavioural SPI flash mock.
`timescale 1ns/1ps
module tb_serial_spi_flash_reader;
  localparam int unsigned WakeCycles = 30;
  localparam int unsigned CsGap      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr = 24'h0;
  logic [8:0]  req_len = 9'd0;
  logic        req_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic        init_done, init_error;
  logic        cs, sclk, si;
  logic        so = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_spi_flash_reader #(
    .WAKE_CYCLES(WakeCycles),
    .CS_GAP     (CsGap),
    .EXPECTED_ID(24'h010000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_ready (req_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .init_done (init_done),
    .init_error(init_error),
    .cs        (cs),
    .sclk      (sclk),
    .si        (si),
    .so        (so)
  );

  // Flash mock: captures si on sclk rise, drives so on sclk fall.
  logic [23:0] mock_id = 24'h010000;
  logic [7:0]  mem [0:511];
  int          mock_bits = 0;
  logic [7:0]  mock_sr = 8'h00;
  logic [7:0]  mock_cmd = 8'h00;
  logic [23:0] mock_addr = 24'h0;
  logic [7:0]  mosi_q [$];
  logic [7:0]  rx_q [$];
  int          cs_rises = 0;
  int          hi_run = 0;
  int          last_gap = 0;

  always @(posedge cs) begin
    mock_bits = 0;
    cs_rises++;
  end

  always @(posedge sclk) begin
    if (!cs) begin
      mock_sr = {mock_sr[6:0], si};
      mock_bits++;
      if (mock_bits % 8 == 0) begin
        mosi_q.push_back(mock_sr);
        if (mock_bits == 8) mock_cmd = mock_sr;
        else if (mock_bits <= 32) mock_addr = {mock_addr[15:0], mock_sr};
      end
    end
  end

  always @(negedge sclk) begin
    int idx;
    logic [7:0] byt;
    if (!cs) begin
      if (mock_cmd == 8'h9F && mock_bits >= 8 && mock_bits < 32) begin
        so = mock_id[23 - (mock_bits - 8)];
      end else if (mock_cmd == 8'h0B && mock_bits >= 40) begin
        idx = (int'(mock_addr) + (mock_bits - 40) / 8) % 512;
        byt = mem[idx];
        so  = byt[7 - ((mock_bits - 40) % 8)];
      end else begin
        so = 1'b0;
      end
    end
  end

  // Consumed bytes, taken with the pre-edge handshake values.
  always @(posedge clk) if (!rst && data_valid && data_ready) rx_q.push_back(data_out);

  // Length of the most recent cs-high stretch, in clk cycles.
  always @(negedge clk) begin
    if (cs) hi_run++;
    else if (hi_run != 0) begin
      last_gap = hi_run;
      hi_run   = 0;
    end
  end

  task automatic wait_init(input int bound);
    int i;
    for (i = 0; i < bound && !(init_done || init_error); i++) @(negedge clk);
    n_vec++;
    if (!(init_done || init_error)) begin
      n_err++;
      $display("FAIL init_timeout: no init_done/init_error after %0d cycles", bound);
    end
  endtask

  task automatic issue(input logic [23:0] a, input logic [8:0] l, input int bound);
    bit ok = 0;
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (ok) begin
      @(posedge clk);
      #1 req_valid = 1'b0;
    end else req_valid = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL req_accept: req_ready not seen within %0d cycles", bound);
    end
  endtask

  task automatic wait_done(input int nbytes, input int bound);
    int i;
    for (i = 0; i < bound && !(rx_q.size() >= nbytes && cs); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_vec++;
    if (rx_q.size() < nbytes || !cs) begin
      n_err++;
      $display("FAIL xfer_timeout: got %0d bytes cs=%b, want %0d bytes cs=1", rx_q.size(), cs,
               nbytes);
    end
  endtask

  task automatic wait_dv(input int bound);
    int i;
    for (i = 0; i < bound && !data_valid; i++) @(negedge clk);
    n_vec++;
    if (!data_valid) begin
      n_err++;
      $display("FAIL dv_timeout: data_valid not seen within %0d cycles", bound);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec += 8;
    if (cs !== 1'b1)        begin n_err++; $display("FAIL rst_cs: got %b want 1", cs); end
    if (sclk !== 1'b0)      begin n_err++; $display("FAIL rst_sclk: got %b want 0", sclk); end
    if (si !== 1'b0)        begin n_err++; $display("FAIL rst_si: got %b want 0", si); end
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_dv: got %b want 0", data_valid); end
    if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", data_out); end
    if (init_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", init_done); end
    if (init_error !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", init_error); end
  endtask

  task automatic test_init;
    int first_fall = 0;
    mock_id = 24'h010000;
    mosi_q.delete();
    rst = 1'b0;
    for (int i = 1; i <= 10 && first_fall == 0; i++) begin
      @(posedge clk);
      #1;
      if (!cs) first_fall = i;
    end
    n_vec++;
    if (first_fall < 2) begin
      n_err++;
      $display("FAIL init_first_cs: cs fell at edge %0d, want edge >= 2", first_fall);
    end
    wait_init(1000);
    n_vec += 5;
    if (init_done !== 1'b1)  begin n_err++; $display("FAIL init_done: got %b want 1", init_done); end
    if (init_error !== 1'b0) begin n_err++; $display("FAIL init_error: got %b want 0", init_error); end
    if (mosi_q.size() < 2) begin
      n_err++;
      $display("FAIL init_bytes: got %0d si bytes want >= 2", mosi_q.size());
    end else begin
      if (mosi_q[0] !== 8'hAB) begin n_err++; $display("FAIL init_wake: got %h want ab", mosi_q[0]); end
      if (mosi_q[1] !== 8'h9F) begin n_err++; $display("FAIL init_rdid: got %h want 9f", mosi_q[1]); end
    end
    if (last_gap < WakeCycles) begin
      n_err++;
      $display("FAIL init_wake_gap: cs high %0d cycles want >= %0d", last_gap, WakeCycles);
    end
  endtask

  task automatic test_read;
    logic [7:0] exp_cmd [5];
    exp_cmd = '{8'h0B, 8'h00, 8'h00, 8'h04, 8'h00};
    rx_q.delete();
    mosi_q.delete();
    data_ready = 1'b1;
    issue(24'h000004, 9'd3, 100);
    cs_rises = 0;
    wait_done(3, 600);
    n_vec += 3;
    if (rx_q.size() != 3) begin n_err++; $display("FAIL read_count: got %0d want 3", rx_q.size()); end
    else for (int i = 0; i < 3; i++)
      if (rx_q[i] !== mem[4 + i]) begin
        n_err++;
        $display("FAIL read_byte%0d: got %h want %h", i, rx_q[i], mem[4 + i]);
      end
    if (mosi_q.size() < 5) begin n_err++; $display("FAIL read_si_count: got %0d want >= 5", mosi_q.size()); end
    else for (int i = 0; i < 5; i++)
      if (mosi_q[i] !== exp_cmd[i]) begin
        n_err++;
        $display("FAIL read_si%0d: got %h want %h", i, mosi_q[i], exp_cmd[i]);
      end
    if (cs_rises != 1) begin n_err++; $display("FAIL read_cs_rises: got %0d want 1", cs_rises); end
  endtask

  task automatic test_backpressure;
    int bad_sclk = 0;
    int bad_cs = 0;
    int bad_data = 0;
    rx_q.delete();
    data_ready = 1'b0;
    issue(24'h000100, 9'd4, 100);
    cs_rises = 0;
    wait_dv(400);
    repeat (3) @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      if (sclk) bad_sclk++;
      if (cs) bad_cs++;
      if (data_out !== mem[256]) bad_data++;
    end
    data_ready = 1'b1;
    wait_done(4, 600);
    n_vec += 5;
    if (bad_sclk != 0) begin n_err++; $display("FAIL bp_sclk: %0d cycles high want 0", bad_sclk); end
    if (bad_cs != 0)   begin n_err++; $display("FAIL bp_cs: %0d cycles high want 0", bad_cs); end
    if (bad_data != 0) begin n_err++; $display("FAIL bp_hold: %0d cycles data changed want 0", bad_data); end
    if (cs_rises != 1) begin n_err++; $display("FAIL bp_cs_rises: got %0d want 1", cs_rises); end
    if (rx_q.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", rx_q.size()); end
    else for (int i = 0; i < 4; i++)
      if (rx_q[i] !== mem[256 + i]) begin
        n_err++;
        $display("FAIL bp_byte%0d: got %h want %h", i, rx_q[i], mem[256 + i]);
      end
  endtask

  task automatic test_len0;
    int bad = 0;
    int seen = 0;
    rx_q.delete();
    data_ready = 1'b1;
    issue(24'h000000, 9'd0, 100);
    wait_done(256, 5000);
    n_vec += 3;
    if (rx_q.size() != 256) begin n_err++; $display("FAIL len0_count: got %0d want 256", rx_q.size()); end
    else for (int i = 0; i < 256; i++) if (rx_q[i] !== mem[i]) bad++;
    if (bad != 0) begin n_err++; $display("FAIL len0_data: %0d bytes wrong want 0", bad); end
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (req_ready) seen = 1;
    end
    if (!seen) begin n_err++; $display("FAIL len0_ready: req_ready=%b want 1", req_ready); end
  endtask

  task automatic test_mismatch;
    int bad = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mock_id = 24'hEF4018;
    rst = 1'b0;
    wait_init(1000);
    n_vec += 3;
    if (init_error !== 1'b1) begin n_err++; $display("FAIL mm_error: got %b want 1", init_error); end
    if (init_done !== 1'b0)  begin n_err++; $display("FAIL mm_done: got %b want 0", init_done); end
    req_addr  = 24'h0;
    req_len   = 9'd1;
    req_valid = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (req_ready || !cs || !init_error) bad++;
    end
    req_valid = 1'b0;
    if (bad != 0) begin n_err++; $display("FAIL mm_idle: %0d bad cycles want 0", bad); end
  endtask

  task automatic test_held_request;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mock_id = 24'h010000;
    rx_q.delete();
    mosi_q.delete();
    data_ready = 1'b1;
    req_addr  = 24'h000010;
    req_len   = 9'd2;
    req_valid = 1'b1;
    rst = 1'b0;
    issue(24'h000010, 9'd2, 1000);
    wait_done(2, 500);
    n_vec += 3;
    if (init_done !== 1'b1) begin n_err++; $display("FAIL held_done: got %b want 1", init_done); end
    if (mosi_q.size() < 1 || mosi_q[0] !== 8'hAB) begin
      n_err++;
      $display("FAIL held_first_cmd: first si byte wrong, want ab");
    end
    if (rx_q.size() != 2 || rx_q[0] !== mem[16] || rx_q[1] !== mem[17]) begin
      n_err++;
      $display("FAIL held_data: got %0d bytes, want %h %h", rx_q.size(), mem[16], mem[17]);
    end
  endtask

  task automatic test_reset_mid;
    int i;
    rx_q.delete();
    data_ready = 1'b1;
    issue(24'h000020, 9'd4, 100);
    for (i = 0; i < 400 && rx_q.size() < 1; i++) @(negedge clk);
    data_ready = 1'b0;
    wait_dv(100);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec += 5;
    if (cs !== 1'b1)         begin n_err++; $display("FAIL mid_cs: got %b want 1", cs); end
    if (sclk !== 1'b0)       begin n_err++; $display("FAIL mid_sclk: got %b want 0", sclk); end
    if (data_valid !== 1'b0) begin n_err++; $display("FAIL mid_dv: got %b want 0", data_valid); end
    if (init_done !== 1'b0)  begin n_err++; $display("FAIL mid_done: got %b want 0", init_done); end
    if (data_out !== 8'h00)  begin n_err++; $display("FAIL mid_data: got %h want 00", data_out); end
    mosi_q.delete();
    @(negedge clk);
    rst = 1'b0;
    data_ready = 1'b1;
    for (i = 0; i < 200 && mosi_q.size() < 1; i++) @(negedge clk);
    n_vec++;
    if (mosi_q.size() < 1 || mosi_q[0] !== 8'hAB) begin
      n_err++;
      $display("FAIL mid_rewake: %0d si bytes after release, want first byte ab", mosi_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_init();
    test_read();
    test_backpressure();
    test_len0();
    test_mismatch();
    test_held_request();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
